// File: rtl/mips_pkg.sv
// Shared definitions for the multicycle MIPS core.
// Opcode/funct values, FSM state encoding, ALU op encoding, sign-extend helper.
package mips_pkg;

  localparam logic [5:0] OP_R    = 6'h00;
  localparam logic [5:0] OP_J    = 6'h02;
  localparam logic [5:0] OP_BEQ  = 6'h04;
  localparam logic [5:0] OP_ADDI = 6'h08;
  localparam logic [5:0] OP_LW   = 6'h23;
  localparam logic [5:0] OP_SW   = 6'h2B;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_MEM,
    S_WB,
    S_TRAP
  } state_e;

  typedef enum logic [2:0] {
    ALU_ADD,
    ALU_SUB,
    ALU_AND,
    ALU_OR,
    ALU_SLT
  } alu_op_e;

  function automatic logic [31:0] sext16(
    input logic [15:0] v
  );
    return {{16{v[15]}}, v};
  endfunction

endpackage

// File: rtl/mips_alu.sv
// Combinational ALU: add, sub, and, or, signed slt; 32-bit wrap.
// Ports: i_op (alu_op_e), i_a, i_b -> o_y, o_zero (o_y == 0).
module mips_alu
  import mips_pkg::*;
(
  input  alu_op_e     i_op,
  input  logic [31:0] i_a,
  input  logic [31:0] i_b,
  output logic [31:0] o_y,
  output logic        o_zero
);

  always_comb begin
    o_y = 32'h0;
    unique case (i_op)
      ALU_ADD: o_y = i_a + i_b;
      ALU_SUB: o_y = i_a - i_b;
      ALU_AND: o_y = i_a & i_b;
      ALU_OR:  o_y = i_a | i_b;
      ALU_SLT: o_y = {31'h0, $signed(i_a) < $signed(i_b)};
      default: o_y = 32'h0;
    endcase
  end

  assign o_zero = (o_y == 32'h0);

endmodule

// File: rtl/mips_mc_core.sv
// Multicycle MIPS core, one shared req/ready memory port, FSM sequenced.
// Ports: clk, reset (sync, high); mem_req/we/addr/wdata out, mem_rdata/ready in;
// pc, trap out; cyc_cnt/ret_cnt only when MIPS_MC_PERF_EN is defined.
module mips_mc_core
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          PERF_W   = 32
) (
  input  logic              clk,
  input  logic              reset,
  output logic              mem_req,
  output logic              mem_we,
  output logic [31:0]       mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_ready,
  output logic [31:0]       pc,
  output logic              trap
`ifdef MIPS_MC_PERF_EN
  ,
  output logic [PERF_W-1:0] cyc_cnt,
  output logic [PERF_W-1:0] ret_cnt
`endif
);

  if (PERF_W < 1) begin : g_bad_perf_w
    $error("PERF_W must be at least 1");
  end

  state_e      r_state;
  state_e      w_nxt;
  logic [31:0] r_pc;
  logic [31:0] r_ipc;
  logic [31:0] r_ir;
  logic [31:0] r_a;
  logic [31:0] r_b;
  logic [31:0] r_tgt;
  logic [31:0] r_alu;
  logic [31:0] r_mdr;
  logic        r_req;
  logic        r_we;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic        r_trap;
  logic [31:0] r_rf [32];

  logic [5:0]  w_op;
  logic [5:0]  w_fn;
  logic [4:0]  w_rs;
  logic [4:0]  w_rt;
  logic [4:0]  w_rd;
  logic [31:0] w_imm;
  logic        w_is_r;
  logic        w_is_addi;
  logic        w_is_lw;
  logic        w_is_sw;
  logic        w_is_beq;
  logic        w_is_j;
  logic        w_fn_ok;
  logic        w_legal;
  alu_op_e     w_alu_op;
  logic [31:0] w_alu_b;
  logic [31:0] w_y;
  logic        w_zero;
  logic [31:0] w_ra;
  logic [31:0] w_rb;
  logic [31:0] w_pc_ex;
  logic [4:0]  w_wb_dst;
  logic [31:0] w_wb_val;

  assign w_op  = r_ir[31:26];
  assign w_rs  = r_ir[25:21];
  assign w_rt  = r_ir[20:16];
  assign w_rd  = r_ir[15:11];
  assign w_fn  = r_ir[5:0];
  assign w_imm = sext16(r_ir[15:0]);

  assign w_is_r    = (w_op == OP_R);
  assign w_is_addi = (w_op == OP_ADDI);
  assign w_is_lw   = (w_op == OP_LW);
  assign w_is_sw   = (w_op == OP_SW);
  assign w_is_beq  = (w_op == OP_BEQ);
  assign w_is_j    = (w_op == OP_J);

  assign w_fn_ok = (w_fn == FN_ADD) || (w_fn == FN_SUB)
                || (w_fn == FN_AND) || (w_fn == FN_OR)
                || (w_fn == FN_SLT);

  assign w_legal = (w_is_r && w_fn_ok) || w_is_addi
                || w_is_lw || w_is_sw || w_is_beq || w_is_j;

  always_comb begin
    w_alu_op = ALU_ADD;
    unique case (1'b1)
      w_is_r && (w_fn == FN_SUB): w_alu_op = ALU_SUB;
      w_is_r && (w_fn == FN_AND): w_alu_op = ALU_AND;
      w_is_r && (w_fn == FN_OR):  w_alu_op = ALU_OR;
      w_is_r && (w_fn == FN_SLT): w_alu_op = ALU_SLT;
      w_is_beq:                   w_alu_op = ALU_SUB;
      default:                    w_alu_op = ALU_ADD;
    endcase
  end

  assign w_alu_b = (w_is_r || w_is_beq) ? r_b : w_imm;

  mips_alu u_alu (
    .i_op   (w_alu_op),
    .i_a    (r_a),
    .i_b    (w_alu_b),
    .o_y    (w_y),
    .o_zero (w_zero)
  );

  assign w_ra = (w_rs == 5'd0) ? 32'h0 : r_rf[w_rs];
  assign w_rb = (w_rt == 5'd0) ? 32'h0 : r_rf[w_rt];

  // r_pc already points past the instruction here
  assign w_pc_ex = (w_is_beq && w_zero) ? r_tgt
                 : w_is_j ? {r_pc[31:28], r_ir[25:0], 2'b00}
                 : r_pc;

  assign w_wb_dst = w_is_r ? w_rd : w_rt;
  assign w_wb_val = w_is_lw ? r_mdr : r_alu;

  always_comb begin
    w_nxt = r_state;
    unique case (r_state)
      S_FETCH: begin
        if (r_req && mem_ready) w_nxt = S_DECODE;
      end
      S_DECODE: w_nxt = w_legal ? S_EXEC : S_TRAP;
      S_EXEC: begin
        if (w_is_lw || w_is_sw)
          w_nxt = (w_y[1:0] != 2'b00) ? S_TRAP : S_MEM;
        else if (w_is_beq || w_is_j)
          w_nxt = S_FETCH;
        else
          w_nxt = S_WB;
      end
      S_MEM: begin
        if (mem_ready) w_nxt = w_is_lw ? S_WB : S_FETCH;
      end
      S_WB:    w_nxt = S_FETCH;
      S_TRAP:  w_nxt = S_TRAP;
      default: w_nxt = S_FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_FETCH;
    else       r_state <= w_nxt;
  end

  // Bus outputs are registered; every transition into FETCH or MEM
  // launches the next request so zero-wait transfers cost no bubble.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pc    <= RESET_PC;
      r_ipc   <= RESET_PC;
      r_ir    <= 32'h0;
      r_a     <= 32'h0;
      r_b     <= 32'h0;
      r_tgt   <= 32'h0;
      r_alu   <= 32'h0;
      r_mdr   <= 32'h0;
      r_req   <= 1'b0;
      r_we    <= 1'b0;
      r_addr  <= 32'h0;
      r_wdata <= 32'h0;
      r_trap  <= 1'b0;
      for (int i = 0; i < 32; i++) r_rf[i] <= 32'h0;
    end else begin
      unique case (r_state)
        S_FETCH: begin
          if (!r_req) begin
            r_req  <= 1'b1;
            r_we   <= 1'b0;
            r_addr <= r_pc;
          end else if (mem_ready) begin
            r_req <= 1'b0;
            r_ir  <= mem_rdata;
            r_ipc <= r_pc;
            r_pc  <= r_pc + 32'd4;
          end
        end
        S_DECODE: begin
          r_a   <= w_ra;
          r_b   <= w_rb;
          r_tgt <= r_pc + (w_imm << 2);
          if (!w_legal) begin
            r_pc   <= r_ipc;
            r_trap <= 1'b1;
          end
        end
        S_EXEC: begin
          r_alu <= w_y;
          r_pc  <= w_pc_ex;
          if (w_nxt == S_MEM) begin
            r_req   <= 1'b1;
            r_we    <= w_is_sw;
            r_addr  <= w_y;
            r_wdata <= r_b;
          end else if (w_nxt == S_TRAP) begin
            r_pc   <= r_ipc;
            r_trap <= 1'b1;
          end else if (w_nxt == S_FETCH) begin
            r_req  <= 1'b1;
            r_we   <= 1'b0;
            r_addr <= w_pc_ex;
          end
        end
        S_MEM: begin
          if (mem_ready) begin
            r_req <= 1'b0;
            r_we  <= 1'b0;
            r_mdr <= mem_rdata;
            if (w_nxt == S_FETCH) begin
              r_req  <= 1'b1;
              r_addr <= r_pc;
            end
          end
        end
        S_WB: begin
          if (w_wb_dst != 5'd0) r_rf[w_wb_dst] <= w_wb_val;
          r_req  <= 1'b1;
          r_we   <= 1'b0;
          r_addr <= r_pc;
        end
        S_TRAP: begin
          r_req <= 1'b0;
        end
        default: begin
          r_req <= 1'b0;
        end
      endcase
    end
  end

  assign mem_req   = r_req;
  assign mem_we    = r_we;
  assign mem_addr  = r_addr;
  assign mem_wdata = r_wdata;
  assign pc        = r_pc;
  assign trap      = r_trap;

`ifdef MIPS_MC_PERF_EN
  logic              w_retire;
  logic [PERF_W-1:0] r_cyc;
  logic [PERF_W-1:0] r_ret;

  assign w_retire = ((r_state == S_EXEC) && (w_is_beq || w_is_j))
                 || ((r_state == S_MEM) && mem_ready && w_is_sw)
                 || (r_state == S_WB);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cyc <= '0;
      r_ret <= '0;
    end else begin
      r_cyc <= r_cyc + PERF_W'(1);
      if (w_retire) r_ret <= r_ret + PERF_W'(1);
    end
  end

  assign cyc_cnt = r_cyc;
  assign ret_cnt = r_ret;
`endif

endmodule
